// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM sequencing the multicycle CPU datapath.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    output logic             SelectIns,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             BEQ,
    output logic [1:0]       PCSrc,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
        MEM_RD, WB_M, MEM_WR, BRANCH, JUMP, ILLEGAL, HALT
    } stateT;
    stateT state, nextState;
    logic [5:0] opQ;
    logic retire;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nextState;
    end
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:     nextState = run ? FETCH : IDLE;
            FETCH:    nextState = DECODE;
            DECODE:
                unique case (opcode)
                    OP_R:         nextState = EXEC_R;
                    OP_ADDI:      nextState = EXEC_I;
                    OP_LW, OP_SW: nextState = MEM_ADDR;
                    OP_BEQ:       nextState = BRANCH;
                    OP_J:         nextState = JUMP;
                    OP_HALT:      nextState = HALT;
                    default:      nextState = ILLEGAL;
                endcase
            EXEC_R:   nextState = WB_R;
            EXEC_I:   nextState = WB_I;
            MEM_ADDR: nextState = opQ == OP_SW ? MEM_WR : MEM_RD;
            MEM_RD:   nextState = WB_M;
            WB_R, WB_I, WB_M, MEM_WR, BRANCH, JUMP, ILLEGAL:
                      nextState = run ? FETCH : IDLE;
            HALT:     nextState = HALT;
            default:  nextState = IDLE;
        endcase
    end
    always_comb begin
        retire    = state inside {WB_R, WB_I, WB_M, MEM_WR, BRANCH, JUMP};
        SelectIns = state == FETCH;
        PCWrite   = state == FETCH || state == JUMP;
        RegWrite  = state inside {WB_R, WB_I, WB_M};
        RegDst    = state == WB_R;
        ALUSrcA   = state inside {EXEC_R, EXEC_I, MEM_ADDR, BRANCH};
        ALUSrcB   = state == FETCH ? 2'b01 : state inside {DECODE, EXEC_I, MEM_ADDR} ? 2'b10 : 2'b00;
        ALUOp     = state == EXEC_R ? 2'b10 : state == BRANCH ? 2'b01 : 2'b00;
        MemWrite  = state == MEM_WR;
        MemtoReg  = state == WB_M;
        BEQ       = state == BRANCH;
        PCSrc     = state == BRANCH ? 2'b01 : state == JUMP ? 2'b10 : 2'b00;
        busy      = !(state == IDLE || state == HALT);
        halted    = state == HALT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opQ         <= '0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            if (state == DECODE) opQ <= opcode;
            if (nextState == ILLEGAL) illegal <= 1'b1;
            if (retire && !(&instr_count)) instr_count <= instr_count + CNT_W'(1);
        end
    end
endmodule
